// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Frame states plus oversampling and data-width constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int SAMPLE_MID = 7;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_parity.sv
// Parity checker for the UART receiver.
// Error flag is registered and only updates on errorCheck_en.
module uart_rx_parity
    import uart_pkg::*;
#(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 errorCheck_en,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 pbit,
    output logic                 parity_err
);

    logic err_next;

    assign err_next = ^data ^ pbit ^ PARITY_ODD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (errorCheck_en) begin
            parity_err <= err_next;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sync, 16x oversample, frame FSM, hold/ack.
// Define UART_RX_PARITY_EN for 8E1/8O1 frames; default build is 8N1.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 27,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       rx_busy
);

    localparam int SAMP_W = $clog2(OVERSAMPLE);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [SAMP_W-1:0] MID = SAMP_W'(SAMPLE_MID);
    localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

    rx_state_t             state;
    logic                  rx_meta;
    logic                  rxs;
    logic [15:0]           div_cnt;
    logic [SAMP_W-1:0]     samp;
    logic [2:0]            idx;
    logic [DATA_BITS-1:0]  data_sh;
    logic                  tick;
    logic                  mid;
    logic                  chk_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign tick    = (div_cnt == DIV_LAST);
    assign mid     = tick && (samp == MID);
    assign rx_busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    logic errorCheck_en;

    assign errorCheck_en = (state == PARITY) && mid;

    uart_rx_parity #(
        .PARITY_ODD (PARITY_ODD)
    ) u_parity (
        .clk           (clk),
        .rst           (rst),
        .errorCheck_en (errorCheck_en),
        .data          (data_sh),
        .pbit          (rxs),
        .parity_err    (chk_err)
    );
`else
    logic unused_parity_odd;

    assign unused_parity_odd = PARITY_ODD;
    assign chk_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            div_cnt     <= '0;
            samp        <= '0;
            idx         <= '0;
            data_sh     <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            // Counters idle at zero so every frame starts phase-aligned
            if (state == IDLE) begin
                div_cnt <= '0;
                samp    <= '0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 16'd1;
                if (tick) samp <= samp + 1'b1;
            end

            if (rx_ack && rx_valid) begin
                rx_valid    <= 1'b0;
                parity_err  <= 1'b0;
                frame_err   <= 1'b0;
                overrun_err <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (!rxs) state <= START;
                end
                START: begin
                    if (mid) begin
                        idx   <= '0;
                        state <= rxs ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (mid) begin
                        data_sh[idx] <= rxs;
                        if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (mid) state <= STOP;
                end
                STOP: begin
                    // Completion overrides a same-cycle ack
                    if (mid) begin
                        rx_data     <= data_sh;
                        frame_err   <= ~rxs;
                        parity_err  <= chk_err;
                        rx_valid    <= 1'b1;
                        overrun_err <= rx_valid && !rx_ack;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl at CLK_DIV = 4.
// Parity expectations follow whether UART_RX_PARITY_EN is defined.
module tb_uart_rx_ctrl;

    localparam int CLK_DIV = 4;
    localparam int BIT     = 16 * CLK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;
    logic       rx_busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    uart_rx_ctrl #(
        .CLK_DIV    (CLK_DIV),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_ack      (rx_ack),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_perr(input logic [7:0] d, input logic p);
        return PAR_EN ? (^d ^ p) : 1'b0;
    endfunction

    // Stop bit is 48 clocks (sampled at 35), then 80 idle clocks
    task automatic send(input logic [7:0] d, input logic p,
                        input logic s, input logic ack_mid);
        rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(BIT);
        end
        if (PAR_EN) begin
            rx = p;
            tick(BIT);
        end
        rx = s;
        tick(34);
        rx_ack = ack_mid;
        tick(1);
        rx_ack = 1'b0;
        tick(13);
        rx = 1'b1;
        tick(80);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] d,
                            input logic pe, input logic fe,
                            input logic ov);
        check({tag, "_data"}, rx_data, d);
        check({tag, "_valid"}, 8'(rx_valid), 8'd1);
        check({tag, "_perr"}, 8'(parity_err), 8'(pe));
        check({tag, "_ferr"}, 8'(frame_err), 8'(fe));
        check({tag, "_ovr"}, 8'(overrun_err), 8'(ov));
    endtask

    task automatic do_ack(input string tag);
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        check({tag, "_ack_valid"}, 8'(rx_valid), 8'd0);
        check({tag, "_ack_flags"},
              8'({parity_err, frame_err, overrun_err}), 8'd0);
    endtask

    initial begin
        logic seen;

        tick(5);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", 8'(rx_valid), 8'd0);
        check("rst_flags",
              8'({parity_err, frame_err, overrun_err}), 8'd0);
        check("rst_busy", 8'(rx_busy), 8'd0);
        rst = 1'b0;

        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            seen = seen | rx_busy | rx_valid | parity_err
                 | frame_err | overrun_err;
        end
        check("idle_quiet", 8'(seen), 8'd0);

        send(8'hC0, 1'b0, 1'b1, 1'b0);
        check_rx("c0", 8'hC0, 1'b0, 1'b0, 1'b0);
        do_ack("c0");

        send(8'hF0, 1'b1, 1'b1, 1'b0);
        check_rx("f0", 8'hF0, exp_perr(8'hF0, 1'b1), 1'b0, 1'b0);
        do_ack("f0");

        send(8'hA5, 1'b0, 1'b0, 1'b0);
        check_rx("a5", 8'hA5, 1'b0, 1'b1, 1'b0);
        do_ack("a5");

        rx = 1'b0;
        tick(20);
        rx = 1'b1;
        tick(5);
        check("fs_busy_hi", 8'(rx_busy), 8'd1);
        tick(40);
        check("fs_busy_lo", 8'(rx_busy), 8'd0);
        check("fs_valid", 8'(rx_valid), 8'd0);

        send(8'h11, 1'b0, 1'b1, 1'b0);
        check_rx("x11", 8'h11, 1'b0, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b1, 1'b0);
        check_rx("x22", 8'h22, 1'b0, 1'b0, 1'b1);
        do_ack("x22");

        send(8'h33, 1'b0, 1'b1, 1'b0);
        check_rx("x33", 8'h33, 1'b0, 1'b0, 1'b0);
        send(8'h44, 1'b0, 1'b1, 1'b1);
        check_rx("x44", 8'h44, 1'b0, 1'b0, 1'b0);
        do_ack("x44");

        rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            tick(BIT);
        end
        rx = 1'b0;
        tick(30);
        rst = 1'b1;
        rx = 1'b1;
        tick(2);
        check("mid_rst_busy", 8'(rx_busy), 8'd0);
        rst = 1'b0;
        tick(200);
        check("abort_valid", 8'(rx_valid), 8'd0);
        check("abort_data", rx_data, 8'h00);
        check("abort_busy", 8'(rx_busy), 8'd0);
        check("abort_flags",
              8'({parity_err, frame_err, overrun_err}), 8'd0);

        send(8'h3C, 1'b0, 1'b1, 1'b0);
        check_rx("x3c", 8'h3C, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
